// File: rtl/sub_serial_16_if.sv
// Operand/result handshake bundle for sub_serial_16.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface sub_serial_16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sub_in1;
  logic [WIDTH-1:0] sub_in2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, sub_in1, sub_in2, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, sub_in1, sub_in2, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/sub_serial_16.sv
// Bit-serial subtractor: diff = sub_in1 - sub_in2 - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module sub_serial_16 #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  sub_serial_16_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             in_ready_c;
  logic             out_valid_c;
  logic             d_bit;
  logic             borrow_nxt;
  logic             last_bit;

  assign d_bit      = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
  assign borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  assign last_bit   = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      borrow_q <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_SHIFT;
      S_SHIFT: if (last_bit)     state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_c  = 1'b1;
      S_DONE:  out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load in IDLE, shift in SHIFT, hold everywhere else.
  always_comb begin
    count_d  = count_q;
    borrow_d = borrow_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.sub_in1;
          b_sh_d   = bus.sub_in2;
          borrow_d = bus.bin;
          count_d  = '0;
`ifdef SUB_OVF_EN
          a_msb_d  = bus.sub_in1[WIDTH-1];
          b_msb_d  = bus.sub_in2[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = borrow_nxt;
        if (last_bit) begin
          // Wrap to zero rather than overflow when WIDTH is not a power of two.
          count_d = '0;
          bout_d  = borrow_nxt;
`ifdef SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_sub_serial_16.sv
// Directed and table-driven bench for sub_serial_16; ovf checks compile in with SUB_OVF_EN.
module tb_sub_serial_16;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  sub_serial_16_if #(.WIDTH(16)) bus();
  sub_serial_16 #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_ovf(output logic ov);
`ifdef SUB_OVF_EN
    ov = bus.ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output logic [15:0] d, output logic bo, output logic ov, output int lat);
    int n;
    @(negedge clk);
    bus.sub_in1  = a;
    bus.sub_in2  = b;
    bus.bin      = bi;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    d  = bus.diff;
    bo = bus.bout;
    get_ovf(ov);
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("consume_out_valid_drop", bus.out_valid, 1'b0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", bus.out_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          lat;
    int          bad;
    int          prev_acc;
    int          acc;
    logic [15:0] ra, rb;
    logic        rbi;
    logic [16:0] ref_val;

    vecs[0]  = '{16'h0202, 16'h0002, 1'b0, 16'h0200, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'h1000, 16'h2000, 1'b0, 16'hF000, 1'b1, 1'b0};
    vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sub_in1   = '0;
    bus.sub_in2   = '0;
    bus.bin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_diff", bus.diff, 16'h0000);
    chk("reset_bout", bus.bout, 1'b0);
    get_ovf(ov);
    chk("reset_ovf", ov, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, ov, lat);
      chk($sformatf("vec%0d_latency", i), lat, 16);
      chk($sformatf("vec%0d_diff", i), d, vecs[i].exp_diff);
      chk($sformatf("vec%0d_bout", i), bo, vecs[i].exp_bout);
`ifdef SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
`endif
      consume();
    end

    // Stall in DONE with stray in_valid pulses during SHIFT and DONE.
    @(negedge clk);
    bus.sub_in1  = 16'h4321;
    bus.sub_in2  = 16'h0321;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("shift_in_ready_low", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sub_in1  = 16'hFFFF;
      bus.sub_in2  = 16'h0000;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    wait_out_valid();
    chk("stall_diff", bus.diff, 16'h4000);
    chk("stall_bout", bus.bout, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.sub_in1  = 16'(i * 7);
      if (!bus.out_valid || bus.diff !== 16'h4000 || bus.in_ready) bad++;
    end
    chk("stall_hold_stable", bad, 0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sub_in1   = 16'h0009;
    bus.sub_in2   = 16'h0003;
    bus.bin       = 1'b0;
    @(posedge clk);
    #1;
    chk("done_consume_out_valid", bus.out_valid, 1'b0);
    chk("done_consume_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("accept_after_done", bus.in_ready, 1'b0);
    @(negedge clk);
    wait_out_valid();
    chk("after_done_diff", bus.diff, 16'h0006);
    consume();

    // Abort mid-SHIFT at count=7.
    @(negedge clk);
    bus.sub_in1  = 16'h0000;
    bus.sub_in2  = 16'h0001;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_diff", bus.diff, 16'h0000);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_bout", bus.bout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h1234, 16'h0234, 1'b0, d, bo, ov, lat);
    chk("post_abort_latency", lat, 16);
    chk("post_abort_diff", d, 16'h1000);
    chk("post_abort_bout", bo, 1'b0);
    consume();

    // Back-to-back with out_ready tied high.
    @(negedge clk);
    bus.out_ready = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 6; k++) begin
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      rbi = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.sub_in1  = ra;
      bus.sub_in2  = rb;
      bus.bin      = rbi;
      bus.in_valid = 1'b1;
      bad = 0;
      while (!bus.in_ready && bad < 40) begin
        @(negedge clk);
        bad++;
      end
      acc = cyc;
      if (k > 0) chk($sformatf("b2b%0d_period", k), acc - prev_acc, 18);
      prev_acc = acc;
      @(posedge clk);
      @(negedge clk);
      wait_out_valid();
      ref_val = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbi};
      chk($sformatf("b2b%0d_diff", k), bus.diff, ref_val[15:0]);
      chk($sformatf("b2b%0d_bout", k), bus.bout, ref_val[16]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("b2b_final_idle", bus.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
